// File: rtl/arrow_scancode_pkg.sv
// Shared constants and types for the arrow-key scancode path.
//   SC_EXT / SC_BREAK : PS/2 set-2 extended prefix and break prefix bytes
//   SC_LEFT..SC_UP    : arrow-key codes, also used by the arrow-key decoder
//   tx_state_e        : transmitter sequence states (IDLE/PREFIX/BRK/CODE)
//   key_code()        : key index (0=left,1=down,2=right,3=up) -> code byte
//   lowest_set()      : index of the lowest set bit of a 4-bit vector
package arrow_scancode_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_BRK    = 2'd2,
    ST_CODE   = 2'd3
  } tx_state_e;

  function automatic logic [7:0] key_code(input logic [1:0] idx);
    case (idx)
      2'd0:    key_code = SC_LEFT;
      2'd1:    key_code = SC_DOWN;
      2'd2:    key_code = SC_RIGHT;
      default: key_code = SC_UP;
    endcase
  endfunction

  // Scans from the top down so the lowest set index wins.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest_set = 2'(i);
    end
  endfunction

endpackage

// File: rtl/arrow_typematic_timer.sv
// Typematic delay/period counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : drop back to the initial-delay phase with a zero count
//   enable     : count this cycle
//   fire       : high on the enabled cycle that completes the current interval
// The first interval is REPEAT_DELAY clocks, every later one REPEAT_PERIOD
// clocks, until clear. The count freezes while enable is low, so the
// in-flight repeat sequence does not restart the delay phase.
module arrow_typematic_timer #(
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 100,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             armed_q, armed_d;  // first repeat already fired
  logic [CNT_W-1:0] limit;

  always_comb begin
    limit   = armed_q ? PERIOD_LAST : DELAY_LAST;
    fire    = enable && !clear && (count_q == limit);
    count_d = count_q;
    armed_d = armed_q;
    if (clear) begin
      count_d = '0;
      armed_d = 1'b0;
    end else if (fire) begin
      count_d = '0;
      armed_d = 1'b1;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/arrow_scancode_tx.sv
// Arrow-key scancode transmitter (PS/2 set-2 extended make/break).
//   clk, reset           : clock, synchronous active-high reset
//   left/down/right/up   : debounced level inputs, synchronous to clk
//   tx_data/tx_valid     : scancode byte stream out
//   tx_ready             : byte accepted when tx_valid && tx_ready
//   busy                 : high whenever a sequence is in flight
// Handshake: once tx_valid rises, tx_valid and tx_data hold until the cycle
// tx_valid && tx_ready is true; only that cycle advances the sequence.
// Optional feature: define TYPEMATIC_EN to re-send the make of the most
// recently pressed key while it stays held (arrow_typematic_timer).
module arrow_scancode_tx
  import arrow_scancode_pkg::*;
#(
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 100,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       down,
  input  logic       right,
  input  logic       up,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  tx_state_e  state_q, state_d;
  logic [3:0] key_q, key_d;
  logic [3:0] reported_q, reported_d;  // key state last fully sent
  logic [1:0] idx_q, idx_d;            // key of the sequence in flight
  logic       is_break_q, is_break_d;
  logic [3:0] pending;
  logic       accept;
  logic       rpt_fire;

  assign pending = key_q ^ reported_q;
  assign accept  = tx_valid && tx_ready;

`ifdef TYPEMATIC_EN
  logic [1:0] last_idx_q, last_idx_d;
  logic       last_valid_q, last_valid_d;
  logic       held, rpt_enable, rpt_clear;

  // "Most recently made key still held" = reported as made and still down.
  assign held       = last_valid_q && key_q[last_idx_q] && reported_q[last_idx_q];
  assign rpt_enable = (state_q == ST_IDLE) && (pending == 4'd0) && held;
  assign rpt_clear  = !held || ((state_q == ST_IDLE) && (pending != 4'd0));

  always_comb begin
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    if (state_q == ST_CODE && accept && !is_break_q) begin
      last_idx_d   = idx_q;
      last_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_idx_q   <= 2'd0;
      last_valid_q <= 1'b0;
    end else begin
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
    end
  end

  arrow_typematic_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (rpt_clear),
    .enable(rpt_enable),
    .fire  (rpt_fire)
  );
`else
  localparam int unused_cfg = REPEAT_DELAY + REPEAT_PERIOD + CNT_W;
  assign rpt_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      key_q      <= 4'd0;
      reported_q <= 4'd0;
      idx_q      <= 2'd0;
      is_break_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      reported_q <= reported_d;
      idx_q      <= idx_d;
      is_break_q <= is_break_d;
    end
  end

  // Next-state logic.
  always_comb begin
    key_d      = {up, right, down, left};
    state_d    = state_q;
    reported_d = reported_q;
    idx_d      = idx_q;
    is_break_d = is_break_q;
    case (state_q)
      ST_IDLE: begin
        if (pending != 4'd0) begin
          idx_d      = lowest_set(pending);
          is_break_d = reported_q[lowest_set(pending)];
          state_d    = ST_PREFIX;
        end else if (rpt_fire) begin
`ifdef TYPEMATIC_EN
          idx_d      = last_idx_q;
`endif
          is_break_d = 1'b0;
          state_d    = ST_PREFIX;
        end
      end
      ST_PREFIX: if (accept) state_d = is_break_q ? ST_BRK : ST_CODE;
      ST_BRK:    if (accept) state_d = ST_CODE;
      ST_CODE: begin
        if (accept) begin
          reported_d[idx_q] = ~is_break_q;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they are stable while waiting.
  always_comb begin
    tx_valid = (state_q != ST_IDLE);
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_PREFIX: tx_data = SC_EXT;
      ST_BRK:    tx_data = SC_BREAK;
      ST_CODE:   tx_data = key_code(idx_q);
      default:   tx_data = 8'h00;
    endcase
  end

endmodule
